// File: rtl/tree_compare_pkg.sv
// Shared node type and sizing helpers for the pipelined minimum tree.
package tree_compare_pkg;

   localparam int NODE_DW = 64;
   localparam int NODE_IW = 7;

   typedef struct packed {
      logic               valid;
      logic [NODE_DW-1:0] value;
      logic [NODE_IW-1:0] index;
   } node_t;

   function automatic int tc_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int tc_nodes(input int n, input int lvl);
      int c;
      c = n;
      for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
      return c;
   endfunction

endpackage

// File: rtl/tree_compare_node.sv
// One two-input unsigned minimum; the left operand wins ties.
module tree_compare_node
   import tree_compare_pkg::*;
(
   input  node_t i_a,
   input  node_t i_b,
   output node_t o_y
);

   logic w_take_a;

   // left operand always precedes the right one in priority order
   assign w_take_a = i_a.valid &&
                     (!i_b.valid || (i_a.value <= i_b.value));
   assign o_y = w_take_a ? i_a : i_b;

endmodule

// File: rtl/pipelined_tree_compare_solver.sv
// Pipelined minimum over a default plus valid channels, one register per level.
// Define TREE_COMPARE_INDEX_EN to add result_index and index tracking.
module pipelined_tree_compare_solver
   import tree_compare_pkg::*;
#(
   parameter  int DATA_WIDTH    = 8,
   parameter  int CHANNEL_COUNT = 5,
   localparam int LEVELS        = tc_clog2(CHANNEL_COUNT + 1),
   localparam int IDX_WIDTH     = tc_clog2(CHANNEL_COUNT + 1)
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_WIDTH-1:0]               default_value,
   input  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] values,
   input  logic [CHANNEL_COUNT-1:0]            valids,
   output logic                                out_valid,
   output logic [DATA_WIDTH-1:0]               result,
`ifdef TREE_COMPARE_INDEX_EN
   output logic [IDX_WIDTH-1:0]                result_index,
`endif
   input  logic                                out_ready
);

`ifdef TREE_COMPARE_INDEX_EN
   localparam bit IDX_EN = 1'b1;
`else
   localparam bit IDX_EN = 1'b0;
`endif

   localparam int LEAVES = CHANNEL_COUNT + 1;

   node_t       w_leaf [LEAVES];
   node_t       w_src  [LEVELS][LEAVES];
   node_t       w_cmp  [LEVELS][LEAVES];
   node_t       r_stg  [LEVELS][LEAVES];
   logic [LEVELS-1:0] r_sv;
   logic        w_adv;
   node_t       w_fin;
   logic        w_unused;

   // default sits leftmost so it wins every tie
   assign w_leaf[0] = '{
      valid: 1'b1,
      value: NODE_DW'(default_value),
      index: IDX_EN ? NODE_IW'(CHANNEL_COUNT) : '0
   };

   for (genvar i = 0; i < CHANNEL_COUNT; i++) begin : g_leaf
      assign w_leaf[i+1] = '{
         valid: valids[i],
         value: NODE_DW'(values[i*DATA_WIDTH +: DATA_WIDTH]),
         index: IDX_EN ? NODE_IW'(i) : '0
      };
   end

   for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
      localparam int N_IN = tc_nodes(LEAVES, k);

      if (k == 0) begin : g_src
         assign w_src[k] = w_leaf;
      end else begin : g_src
         assign w_src[k] = r_stg[k-1];
      end

      for (genvar j = 0; j < LEAVES; j++) begin : g_node
         if (2*j + 1 < N_IN) begin : g_cmp
            tree_compare_node u_node (
               .i_a (w_src[k][2*j]),
               .i_b (w_src[k][2*j+1]),
               .o_y (w_cmp[k][j])
            );
         end else if (2*j < N_IN) begin : g_pass
            assign w_cmp[k][j] = w_src[k][2*j];
         end else begin : g_zero
            assign w_cmp[k][j] = '0;
         end
      end
   end

   assign out_valid = r_sv[LEVELS-1];
   assign w_adv     = !out_valid || out_ready;
   assign in_ready  = w_adv;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sv <= '0;
         for (int k = 0; k < LEVELS; k++)
            for (int j = 0; j < LEAVES; j++)
               r_stg[k][j] <= '0;
      end else if (w_adv) begin
         r_sv[0] <= in_valid;
         for (int k = 1; k < LEVELS; k++)
            r_sv[k] <= r_sv[k-1];
         r_stg <= w_cmp;
      end
   end

   assign w_fin  = r_stg[LEVELS-1][0];
   assign result = w_fin.value[DATA_WIDTH-1:0];

`ifdef TREE_COMPARE_INDEX_EN
   assign result_index = w_fin.index[IDX_WIDTH-1:0];
`endif

   assign w_unused = ^{w_fin.valid,
                       w_fin.value >> DATA_WIDTH,
                       IDX_EN ? (w_fin.index >> IDX_WIDTH)
                              : w_fin.index};

endmodule
